// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder and the decode stage.
package rv_isa_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FMT_W  = 3;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [F7_W-1:0] F7_BASE = 7'h00;
  localparam logic [F7_W-1:0] F7_ALT  = 7'h20;

  // Producer-side instruction format selector; codes 5..7 are never legal.
  typedef enum logic [FMT_W-1:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_LOAD   = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4
  } fmt_e;

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through FIFO holding encoded instruction words until memory takes them.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = store[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Assembles RV32I instruction words from field bundles, drops illegal ones, and
// streams legal words into instruction memory at sequential word addresses.
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  fmt,
  input  logic [F3_W-1:0]   funct3,
  input  logic [F7_W-1:0]   funct7,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [XLEN-1:0]   imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [15:0]       words_written
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WW_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] word_c;
  logic            legal_c;
  logic            is_shift_c;
  logic            imm_s12_c;
  logic            imm_b13_c;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [XLEN-1:0] fifo_head;

  assign is_shift_c = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign imm_s12_c  = (imm[31:11] == '0) || (imm[31:11] == '1);
  // Branch offsets are 13-bit signed and must be halfword aligned.
  assign imm_b13_c  = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];

  always_comb begin
    word_c  = '0;
    legal_c = 1'b0;
    case (fmt)
      FMT_R: begin
        word_c  = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal_c = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      FMT_I: begin
        if (is_shift_c) begin
          word_c  = {funct7, imm[4:0], rs1, funct3, rd, OP_IMM};
          legal_c = (imm[31:5] == '0) &&
                    ((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == 3'b101)));
        end else begin
          word_c  = {imm[11:0], rs1, funct3, rd, OP_IMM};
          legal_c = imm_s12_c;
        end
      end
      FMT_LOAD: begin
        word_c  = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal_c = imm_s12_c && (funct3 != 3'b011) && (funct3 != 3'b110) &&
                  (funct3 != 3'b111);
      end
      FMT_STORE: begin
        word_c  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal_c = imm_s12_c && (funct3 <= 3'b010);
      end
      FMT_BRANCH: begin
        word_c  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        legal_c = imm_b13_c && (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      default: begin
        word_c  = '0;
        legal_c = 1'b0;
      end
    endcase
  end

  // Ready looks only at registered fullness, so a same-cycle pop never bypasses.
  assign in_ready = rst_n && !fifo_full && !clear;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal_c;
  assign pop      = mem_we && mem_ready && !clear;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .wdata (word_c),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_we    = !fifo_empty;
  assign mem_wdata = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr      <= BASE_ADDR;
      err           <= 1'b0;
      err_count     <= '0;
      words_written <= '0;
    end else begin
      err <= accept && !legal_c;
      if (accept && !legal_c && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (clear) begin
        mem_addr <= BASE_ADDR;
      end else if (pop) begin
        mem_addr      <= mem_addr + ADDR_W'(4);
        words_written <= words_written + WW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised self-checking bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 6;
  localparam logic [ADDR_W-1:0] BASE = '0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic        mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int unsigned q[$];
  int unsigned m_addr;
  int unsigned m_errc;
  int unsigned m_ww;
  bit          m_err;
  bit          m_acc;

  int bnd[10] = '{-4098, -4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096};

  instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fmt           (fmt),
    .funct3        (funct3),
    .funct7        (funct7),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .imm           (imm),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .err           (err),
    .err_count     (err_count),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Encoding rules written as field arithmetic on integers.
  function automatic void ref_encode(input int unsigned f, input int unsigned f3,
                                     input int unsigned f7, input int unsigned r_d,
                                     input int unsigned r1, input int unsigned r2,
                                     input int im, output bit ok, output int unsigned w);
    int unsigned u;
    u  = int'(im);
    ok = 1'b0;
    w  = 0;
    case (f)
      0: begin
        ok = (f7 == 0) || (f7 == 32);
        w  = (f7 << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12) + (r_d << 7) + 'h33;
      end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (im >= 0) && (im <= 31) && ((f7 == 0) || (f7 == 32 && f3 == 5));
          w  = (f7 << 25) + ((u & 31) << 20) + (r1 << 15) + (f3 << 12) + (r_d << 7) + 'h13;
        end else begin
          ok = (im >= -2048) && (im <= 2047);
          w  = ((u & 'hfff) << 20) + (r1 << 15) + (f3 << 12) + (r_d << 7) + 'h13;
        end
      end
      2: begin
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) &&
             (im >= -2048) && (im <= 2047);
        w  = ((u & 'hfff) << 20) + (r1 << 15) + (f3 << 12) + (r_d << 7) + 'h03;
      end
      3: begin
        ok = (f3 <= 2) && (im >= -2048) && (im <= 2047);
        w  = (((u >> 5) & 'h7f) << 25) + (r2 << 20) + (r1 << 15) + (f3 << 12) +
             ((u & 'h1f) << 7) + 'h23;
      end
      4: begin
        ok = (f3 != 2) && (f3 != 3) && ((u % 2) == 0) && (im >= -4096) && (im <= 4094);
        w  = (((u >> 12) & 1) << 31) + (((u >> 5) & 'h3f) << 25) + (r2 << 20) +
             (r1 << 15) + (f3 << 12) + (((u >> 1) & 'hf) << 8) + (((u >> 11) & 1) << 7) + 'h63;
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = BASE;
    m_errc = 0;
    m_ww   = 0;
    m_err  = 0;
    m_acc  = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    bit          ok;
    int unsigned w;
    if (clear) begin
      q.delete();
      m_addr = BASE;
      m_err  = 0;
      m_acc  = 0;
    end else begin
      m_acc = in_valid && (q.size() < DEPTH);
      ref_encode(32'(fmt), 32'(funct3), 32'(funct7), 32'(rd), 32'(rs1), 32'(rs2),
                 int'(imm), ok, w);
      if (q.size() != 0 && mem_ready) begin
        void'(q.pop_front());
        m_addr = (m_addr + 4) % (1 << ADDR_W);
        m_ww   = (m_ww + 1) % 65536;
      end
      if (m_acc && ok) q.push_back(w);
      m_err = m_acc && !ok;
      if (m_err && m_errc < 255) m_errc++;
    end
  endtask

  task automatic compare_all();
    check("mem_we", 64'(mem_we), (q.size() != 0) ? 1 : 0);
    check("mem_wdata", 64'(mem_wdata), (q.size() != 0) ? 64'(q[0]) : 0);
    check("mem_addr", 64'(mem_addr), 64'(m_addr));
    check("err", 64'(err), 64'(m_err));
    check("err_count", 64'(err_count), 64'(m_errc));
    check("words_written", 64'(words_written), 64'(m_ww));
  endtask

  task automatic reset_checks();
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_mem_wdata", 64'(mem_wdata), 0);
    check("rst_mem_addr", 64'(mem_addr), 64'(BASE));
    check("rst_err", 64'(err), 0);
    check("rst_err_count", 64'(err_count), 0);
    check("rst_words_written", 64'(words_written), 0);
    check("rst_in_ready", 64'(in_ready), 0);
  endtask

  // Called one time unit after an edge with inputs already set for the coming edge.
  task automatic cycle();
    #1;
    check("in_ready", 64'(in_ready), ((q.size() < DEPTH) && !clear) ? 1 : 0);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_fields(input int f, input int f3, input int f7, input int r_d,
                            input int r1, input int r2, input int im);
    fmt    = 3'(f);
    funct3 = 3'(f3);
    funct7 = 7'(f7);
    rd     = 5'(r_d);
    rs1    = 5'(r1);
    rs2    = 5'(r2);
    imm    = 32'(im);
  endtask

  task automatic send(input int f, input int f3, input int f7, input int r_d,
                      input int r1, input int r2, input int im);
    set_fields(f, f3, f7, r_d, r1, r2, im);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic rand_fields();
    int f;
    int f7;
    int im;
    f = int'($urandom_range(0, 9));
    if (f > 7) f = int'($urandom_range(0, 4));
    case ($urandom_range(0, 3))
      0, 1:    f7 = 0;
      2:       f7 = 'h20;
      default: f7 = int'($urandom_range(0, 127));
    endcase
    case ($urandom_range(0, 5))
      0:       im = int'($urandom_range(0, 31));
      1:       im = int'($urandom_range(0, 80)) - 40;
      2:       im = bnd[$urandom_range(0, 9)];
      3:       im = int'($urandom_range(0, 8190)) - 4096;
      4:       im = int'($urandom);
      default: im = 2 * (int'($urandom_range(0, 4095)) - 2048);
    endcase
    set_fields(f, int'($urandom_range(0, 7)), f7, int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), im);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    reset_checks();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R/R/LOAD with memory always ready
    mem_ready = 1'b1;
    send(0, 0, 0, 3, 1, 2, 0);
    check("tp_r0_word", 64'(mem_wdata), 64'h002081B3);
    check("tp_r0_addr", 64'(mem_addr), 0);
    send(0, 0, 'h20, 3, 1, 2, 0);
    check("tp_r1_word", 64'(mem_wdata), 64'h402081B3);
    check("tp_r1_addr", 64'(mem_addr), 4);
    send(2, 2, 0, 5, 2, 0, 8);
    check("tp_ld_word", 64'(mem_wdata), 64'h00812283);
    check("tp_ld_addr", 64'(mem_addr), 8);
    cycle();
    check("tp_ww3", 64'(words_written), 3);

    // STORE, BRANCH, I-ALU
    send(3, 2, 0, 0, 2, 5, 12);
    check("tp_st_word", 64'(mem_wdata), 64'h00512623);
    cycle();
    send(4, 0, 0, 0, 1, 2, -8);
    check("tp_br_word", 64'(mem_wdata), 64'hFE208CE3);
    cycle();
    send(1, 0, 0, 1, 0, 0, 5);
    check("tp_i_word", 64'(mem_wdata), 64'h00500093);
    cycle();

    // Illegal bundles are dropped and counted
    send(4, 0, 0, 0, 1, 2, 3);
    check("tp_err_pulse", 64'(err), 1);
    send(2, 2, 0, 5, 2, 0, 2048);
    send(6, 0, 0, 0, 0, 0, 0);
    cycle();
    check("tp_errc3", 64'(err_count), 3);
    check("tp_err_idle", 64'(err), 0);

    // Backpressure: fifth bundle waits until memory drains
    mem_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int waits;
      set_fields(0, i, 0, i + 1, i + 2, i + 3, 0);
      waits = 0;
      m_acc = 0;
      while (!m_acc && waits < 20) begin
        if (waits == 8) mem_ready = 1'b1;
        cycle();
        waits++;
      end
      if (!m_acc) check("bp_accept_timeout", 0, 1);
      if (i == 3) begin
        #1;
        check("bp_full_ready", 64'(in_ready), 0);
      end
    end
    in_valid = 1'b0;
    repeat (8) cycle();

    // Clear with two words queued and a bundle pending
    mem_ready = 1'b0;
    send(0, 0, 0, 7, 7, 7, 0);
    send(0, 1, 0, 8, 8, 8, 0);
    set_fields(0, 2, 0, 9, 9, 9, 0);
    in_valid = 1'b1;
    clear    = 1'b1;
    cycle();
    check("clr_we", 64'(mem_we), 0);
    check("clr_addr", 64'(mem_addr), 64'(BASE));
    clear    = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Random traffic, holding fields until each bundle is accepted
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || m_acc) begin
        rand_fields();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 29) == 0);
      cycle();
    end
    clear = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (6) cycle();

    // Error counter saturation
    set_fields(7, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    repeat (270) cycle();
    in_valid = 1'b0;
    cycle();
    check("sat_err_count", 64'(err_count), 255);

    // Asynchronous reset in the middle of a held write
    mem_ready = 1'b0;
    send(0, 0, 0, 1, 2, 3, 0);
    send(1, 0, 0, 4, 5, 0, -1);
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    send(2, 0, 0, 6, 7, 0, -2048);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
